// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control FSM: sequences fetch/decode/execute for ld, sd,
// R-type and beq, and drives datapath mux selects and write strobes.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       pc_source,
    output logic       retire,
    output logic       trap,
    output logic [3:0] state
);

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC      = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_TRAP      = 4'd9
    } state_e;

    typedef enum logic [1:0] {
        CLS_LD  = 2'b00,
        CLS_SD  = 2'b01,
        CLS_R   = 2'b10,
        CLS_BEQ = 2'b11
    } cls_e;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_source;
        logic       retire;
        logic       trap;
    } ctl_t;

    state_e state_q, state_d;
    cls_e   cls_q, cls_d;
    ctl_t   ctl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cls_q   <= CLS_LD;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        ctl     = '0;
        case (state_q)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'b01;
                ctl.ir_write  = mem_ready;
                ctl.pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALU computes PC + imm here so BRANCH can use the ALU-out register
                ctl.alu_src_b = 2'b10;
                case (opcode)
                    OP_LD:   begin cls_d = CLS_LD;  state_d = S_MEM_ADDR; end
                    OP_SD:   begin cls_d = CLS_SD;  state_d = S_MEM_ADDR; end
                    OP_R:    begin cls_d = CLS_R;   state_d = S_EXEC;     end
                    OP_BEQ:  begin cls_d = CLS_BEQ; state_d = S_BRANCH;   end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                // opcode may no longer be valid; rely on the class captured in DECODE
                state_d = (cls_q == CLS_SD) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                ctl.retire     = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_WRITE: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
                ctl.retire    = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = 2'b10;
                state_d       = S_R_WB;
            end
            S_R_WB: begin
                ctl.reg_write = 1'b1;
                ctl.retire    = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = 2'b01;
                ctl.pc_source = 1'b1;
                ctl.pc_write  = zero;
                ctl.retire    = 1'b1;
                state_d       = S_FETCH;
            end
            S_TRAP: begin
                ctl.trap = 1'b1;
            end
            default: state_d = S_TRAP;
        endcase
    end

    // Reset masks every control output so nothing strobes during the reset cycle
    assign {pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, mem_to_reg,
            alu_src_a, alu_src_b, alu_op, pc_source, retire, trap} = reset ? ctl_t'('0) : ctl;
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-path model checked every cycle plus
// literal state traces and strobe pins for each directed scenario.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [6:0] opcode;
    logic       pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, mem_to_reg;
    logic       alu_src_a, pc_source, retire, trap;
    logic [1:0] alu_src_b, alu_op;
    logic [3:0] state;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_source;
        logic       retire;
        logic       trap;
    } ctl_t;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source), .retire(retire),
        .trap(trap), .state(state)
    );

    always #5 clk = ~clk;

    ctl_t dut_ctl;
    assign dut_ctl = {pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, mem_to_reg,
                      alu_src_a, alu_src_b, alu_op, pc_source, retire, trap};

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Instruction classes: 0=ld 1=sd 2=R 3=beq 4=illegal; each class walks a fixed
    // list of post-DECODE states, with FETCH/MEM_READ/MEM_WRITE stretched by waits.
    function automatic int classify(input logic [6:0] op);
        case (op)
            OP_LD:   return 0;
            OP_SD:   return 1;
            OP_R:    return 2;
            OP_BEQ:  return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int path_len(input int c);
        case (c)
            0:       return 3;
            1, 2:    return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int path_at(input int c, input int i);
        int p[3];
        case (c)
            0:       p = '{2, 3, 4};
            1:       p = '{2, 5, 0};
            2:       p = '{6, 7, 0};
            3:       p = '{8, 0, 0};
            default: p = '{9, 0, 0};
        endcase
        return p[i];
    endfunction

    function automatic ctl_t exp_ctl(input int st, input bit r, input bit mr, input bit z);
        ctl_t c = '0;
        if (r) return c;
        case (st)
            0: begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
            1: c.alu_src_b = 2'b10;
            2: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            3: begin c.mem_read = 1; c.i_or_d = 1; end
            4: begin c.reg_write = 1; c.mem_to_reg = 1; c.retire = 1; end
            5: begin c.mem_write = 1; c.i_or_d = 1; c.retire = mr; end
            6: begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            7: begin c.reg_write = 1; c.retire = 1; end
            8: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_source = 1; c.pc_write = z; c.retire = 1; end
            9: c.trap = 1;
            default: ;
        endcase
        return c;
    endfunction

    int m_state = 0, m_cls = 0, m_idx = 0;
    bit m_valid = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_state <= 0;
            m_valid <= 1;
        end else if (m_valid) begin
            if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready)
                m_state <= m_state;
            else if (m_state == 0)
                m_state <= 1;
            else if (m_state == 1) begin
                m_cls   <= classify(opcode);
                m_idx   <= 1;
                m_state <= path_at(classify(opcode), 0);
            end else if (m_state == 9)
                m_state <= 9;
            else if (m_idx < path_len(m_cls)) begin
                m_state <= path_at(m_cls, m_idx);
                m_idx   <= m_idx + 1;
            end else
                m_state <= 0;
        end
    end

    bit   rec = 0;
    int   st_tr[$];
    ctl_t ctl_tr[$];

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cycle_ctl", 32'(dut_ctl), 32'(exp_ctl(m_state, reset, mem_ready, zero)));
            chk("cycle_state", 32'(state), 32'(m_state));
            chk("rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
            if (rec) begin
                st_tr.push_back(int'(state));
                ctl_tr.push_back(dut_ctl);
            end
        end
    end

    task automatic cyc(input bit r, input logic [6:0] op, input bit mr, input bit z);
        reset = r; opcode = op; mem_ready = mr; zero = z;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_rec();
        st_tr.delete();
        ctl_tr.delete();
        rec = 1;
    endtask

    task automatic chk_trace(input string name, input int e[$]);
        int bad = -1;
        n_chk++;
        if (st_tr.size() != e.size()) bad = -2;
        else for (int i = 0; i < e.size(); i++) if (bad == -1 && st_tr[i] != e[i]) bad = i;
        if (bad == -1) n_pass++;
        else if (bad == -2) $display("FAIL %s: trace length %0d expected %0d", name, st_tr.size(), e.size());
        else $display("FAIL %s: state[%0d] got %0d expected %0d", name, bad, st_tr[bad], e[bad]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int e[$];
        logic all_trap;

        cyc(1, OP_R, 1, 0);
        cyc(1, OP_R, 1, 0);
        chk("reset_outputs", {28'(state), 4'(0)} | 32'(dut_ctl), 32'd0);

        // R-type, zero-wait
        begin_rec();
        repeat (5) cyc(0, OP_R, 1, 0);
        rec = 0;
        e = '{0, 1, 6, 7, 0};
        chk_trace("r_type_states", e);
        chk("exec_alu_op", 32'(ctl_tr[2].alu_op), 32'h2);
        chk("rwb_wr_ret_m2r", {ctl_tr[3].reg_write, ctl_tr[3].retire, ctl_tr[3].mem_to_reg}, 3'b110);
        cyc(1, OP_R, 1, 0);

        // ld with two wait cycles in MEM_READ
        begin_rec();
        cyc(0, OP_LD, 1, 0); cyc(0, OP_LD, 1, 0); cyc(0, OP_LD, 1, 0);
        cyc(0, OP_LD, 0, 0); cyc(0, OP_LD, 0, 0); cyc(0, OP_LD, 1, 0);
        cyc(0, OP_LD, 1, 0); cyc(0, OP_LD, 1, 0);
        rec = 0;
        e = '{0, 1, 2, 3, 3, 3, 4, 0};
        chk_trace("ld_wait_states", e);
        chk("ld_i_or_d_memread", {ctl_tr[3].i_or_d, ctl_tr[4].i_or_d, ctl_tr[5].i_or_d,
                                  ctl_tr[3].mem_read, ctl_tr[5].mem_read}, 5'b11111);
        chk("ld_wb_m2r_retire", {ctl_tr[6].mem_to_reg, ctl_tr[6].reg_write, ctl_tr[6].retire,
                                 ctl_tr[5].retire}, 4'b1110);
        cyc(1, OP_R, 1, 0);

        // beq taken then not taken
        begin_rec();
        cyc(0, OP_BEQ, 1, 1); cyc(0, OP_BEQ, 1, 1); cyc(0, OP_BEQ, 1, 1);
        cyc(0, OP_BEQ, 1, 0); cyc(0, OP_BEQ, 1, 0); cyc(0, OP_BEQ, 1, 0);
        cyc(0, OP_BEQ, 1, 0);
        rec = 0;
        e = '{0, 1, 8, 0, 1, 8, 0};
        chk_trace("beq_states", e);
        chk("beq_taken", {ctl_tr[2].pc_write, ctl_tr[2].pc_source, ctl_tr[2].alu_op}, 4'b1101);
        chk("beq_not_taken", {ctl_tr[5].pc_write, ctl_tr[5].pc_source, ctl_tr[5].retire}, 3'b011);
        cyc(1, OP_R, 1, 0);

        // sd with opcode changing under MEM_ADDR, one wait in MEM_WRITE
        begin_rec();
        cyc(0, OP_SD, 1, 0); cyc(0, OP_SD, 1, 0); cyc(0, OP_R, 1, 0);
        cyc(0, OP_R, 0, 0); cyc(0, OP_R, 1, 0); cyc(0, OP_R, 0, 0);
        rec = 0;
        e = '{0, 1, 2, 5, 5, 0};
        chk_trace("sd_latched_class", e);
        chk("sd_write_wait", {ctl_tr[3].mem_write, ctl_tr[3].mem_read, ctl_tr[3].retire}, 3'b100);
        chk("sd_write_done", {ctl_tr[4].mem_write, ctl_tr[4].mem_read, ctl_tr[4].retire}, 3'b101);
        cyc(1, OP_R, 1, 0);

        // illegal opcode traps and holds until reset
        begin_rec();
        cyc(0, OP_BAD, 1, 0); cyc(0, OP_BAD, 1, 0);
        repeat (10) cyc(0, OP_BAD, 1, 0);
        rec = 0;
        e = '{0, 1, 9, 9, 9, 9, 9, 9, 9, 9, 9, 9};
        chk_trace("trap_hold", e);
        all_trap = 1'b1;
        for (int i = 2; i < 12 && i < ctl_tr.size(); i++)
            all_trap &= ctl_tr[i].trap & ~ctl_tr[i].mem_read & ~ctl_tr[i].pc_write;
        chk("trap_flag_held", 32'(all_trap), 32'd1);
        cyc(1, OP_BAD, 1, 0);
        begin_rec();
        cyc(0, OP_BAD, 0, 0);
        rec = 0;
        e = '{0};
        chk_trace("trap_reset_fetch", e);
        chk("post_trap_fetch", {ctl_tr[0].trap, ctl_tr[0].mem_read, ctl_tr[0].alu_src_b}, 4'b0101);

        // FETCH wait, then reset in the middle of a MEM_READ wait
        begin_rec();
        cyc(0, OP_LD, 0, 0); cyc(0, OP_LD, 1, 0); cyc(0, OP_LD, 1, 0);
        cyc(0, OP_LD, 1, 0); cyc(0, OP_LD, 0, 0); cyc(0, OP_LD, 0, 0);
        cyc(1, OP_LD, 0, 0); cyc(0, OP_LD, 0, 0);
        rec = 0;
        e = '{0, 0, 1, 2, 3, 3, 3, 0};
        chk_trace("reset_mid_wait", e);
        chk("fetch_wait_strobes", {ctl_tr[0].ir_write, ctl_tr[0].pc_write,
                                   ctl_tr[1].ir_write, ctl_tr[1].pc_write}, 4'b0011);
        begin
            logic any_wb = 1'b0;
            foreach (ctl_tr[i]) any_wb |= ctl_tr[i].reg_write | ctl_tr[i].retire;
            chk("no_wb_after_reset", 32'(any_wb), 32'd0);
        end
        chk("reset_cycle_quiet", 32'(ctl_tr[6]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
